// File: rtl/sram_controller.sv
// 32-bit bus to 16-bit asynchronous SRAM bridge: each word access becomes two
// sequenced half-word accesses, and every SRAM-facing output is registered.
module sram_controller #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int PHASE_CYCLES    = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_rw,
  input  logic [31:0]                i_address,
  input  logic [31:0]                i_wdata,
  output logic [31:0]                o_rdata,
  output logic                       o_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
  output logic [15:0]                o_sram_data,
  input  logic [15:0]                i_sram_data,
  output logic                       o_sram_data_oe,
  output logic                       o_sram_ce_n,
  output logic                       o_sram_oe_n,
  output logic                       o_sram_we_n,
  output logic                       o_sram_lb_n,
  output logic                       o_sram_ub_n
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_RD_LO       = 4'd1;
  localparam logic [3:0] S_RD_HI       = 4'd2;
  localparam logic [3:0] S_WR_LO_SETUP = 4'd3;
  localparam logic [3:0] S_WR_LO_PULSE = 4'd4;
  localparam logic [3:0] S_WR_LO_HOLD  = 4'd5;
  localparam logic [3:0] S_WR_HI_SETUP = 4'd6;
  localparam logic [3:0] S_WR_HI_PULSE = 4'd7;
  localparam logic [3:0] S_WR_HI_HOLD  = 4'd8;
  localparam logic [3:0] S_DONE        = 4'd9;

  logic [3:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       phase_last;
  logic [SRAM_ADDR_WIDTH-2:0] req_hw_q, hw_c;
  logic [31:0]                req_wdata_q, wdata_c;
  logic [15:0]                rd_lo_q;
  logic                       accept;

  logic                       is_lo, is_hi, is_wr, is_rd, is_pulse, is_busy;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_d;
  logic [15:0]                sram_data_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[31:SRAM_ADDR_WIDTH+1], i_address[1:0]};

  assign accept     = (state_q == S_IDLE) && i_enable;
  assign phase_last = (cnt_q == CNT_LAST);

  // On the accepting edge the registers are still empty, so outputs for the
  // first state are built straight from the bus.
  assign hw_c    = (state_q == S_IDLE) ? i_address[SRAM_ADDR_WIDTH:2] : req_hw_q;
  assign wdata_c = (state_q == S_IDLE) ? i_wdata : req_wdata_q;

  // NOTE: every variable gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE:        if (i_enable) state_d = i_rw ? S_WR_LO_SETUP : S_RD_LO;
      S_RD_LO:       if (phase_last) state_d = S_RD_HI;       else cnt_d = cnt_q + 1'b1;
      S_RD_HI:       if (phase_last) state_d = S_DONE;        else cnt_d = cnt_q + 1'b1;
      S_WR_LO_SETUP: state_d = S_WR_LO_PULSE;
      S_WR_LO_PULSE: if (phase_last) state_d = S_WR_LO_HOLD;  else cnt_d = cnt_q + 1'b1;
      S_WR_LO_HOLD:  state_d = S_WR_HI_SETUP;
      S_WR_HI_SETUP: state_d = S_WR_HI_PULSE;
      S_WR_HI_PULSE: if (phase_last) state_d = S_WR_HI_HOLD;  else cnt_d = cnt_q + 1'b1;
      S_WR_HI_HOLD:  state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so the
  // strobes change on the same edge as the state.
  always_comb begin
    is_lo    = state_d inside {S_RD_LO, S_WR_LO_SETUP, S_WR_LO_PULSE, S_WR_LO_HOLD};
    is_hi    = state_d inside {S_RD_HI, S_WR_HI_SETUP, S_WR_HI_PULSE, S_WR_HI_HOLD};
    is_rd    = state_d inside {S_RD_LO, S_RD_HI};
    is_wr    = state_d inside {S_WR_LO_SETUP, S_WR_LO_PULSE, S_WR_LO_HOLD,
                               S_WR_HI_SETUP, S_WR_HI_PULSE, S_WR_HI_HOLD};
    is_pulse = state_d inside {S_WR_LO_PULSE, S_WR_HI_PULSE};
    is_busy  = is_rd || is_wr;

    sram_addr_d = o_sram_addr;
    sram_data_d = o_sram_data;
    if (is_lo) begin
      sram_addr_d = {hw_c, 1'b0};
      sram_data_d = wdata_c[15:0];
    end else if (is_hi) begin
      sram_addr_d = {hw_c, 1'b1};
      sram_data_d = wdata_c[31:16];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      o_ready        <= 1'b0;
      o_rdata        <= '0;
      o_sram_addr    <= '0;
      o_sram_data    <= '0;
      o_sram_data_oe <= 1'b0;
      o_sram_ce_n    <= 1'b1;
      o_sram_oe_n    <= 1'b1;
      o_sram_we_n    <= 1'b1;
      o_sram_lb_n    <= 1'b1;
      o_sram_ub_n    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_ready        <= (state_d == S_DONE);
      o_sram_addr    <= sram_addr_d;
      o_sram_data    <= sram_data_d;
      o_sram_data_oe <= is_wr;
      o_sram_ce_n    <= !is_busy;
      o_sram_oe_n    <= !is_rd;
      o_sram_we_n    <= !is_pulse;
      o_sram_lb_n    <= !is_busy;
      o_sram_ub_n    <= !is_busy;
      if (state_q == S_RD_HI && phase_last) o_rdata <= {i_sram_data, rd_lo_q};
    end
  end

  // NOTE: request and low-half capture registers are always loaded before
  // they are read, so they carry no reset.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      req_hw_q    <= i_address[SRAM_ADDR_WIDTH:2];
      req_wdata_q <= i_wdata;
    end
    if (state_q == S_RD_LO && phase_last) rd_lo_q <= i_sram_data;
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: half-word SRAM model on the pins and
// a word-level reference memory, with directed cases and random traffic.
module tb_sram_controller;

  localparam int SAW = 18;
  localparam int P   = 2;
  localparam int WORD_MASK = (1 << (SAW - 1)) - 1;

  logic           clk;
  logic           i_reset, i_enable, i_rw;
  logic [31:0]    i_address, i_wdata, o_rdata;
  logic           o_ready;
  logic [SAW-1:0] o_sram_addr;
  logic [15:0]    o_sram_data, sram_rdata;
  logic           o_sram_data_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n;
  logic           o_sram_lb_n, o_sram_ub_n;

  sram_controller #(.SRAM_ADDR_WIDTH(SAW), .PHASE_CYCLES(P)) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_rw           (i_rw),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .o_rdata        (o_rdata),
    .o_ready        (o_ready),
    .o_sram_addr    (o_sram_addr),
    .o_sram_data    (o_sram_data),
    .i_sram_data    (sram_rdata),
    .o_sram_data_oe (o_sram_data_oe),
    .o_sram_ce_n    (o_sram_ce_n),
    .o_sram_oe_n    (o_sram_oe_n),
    .o_sram_we_n    (o_sram_we_n),
    .o_sram_lb_n    (o_sram_lb_n),
    .o_sram_ub_n    (o_sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin-level SRAM: drives a junk pattern whenever it is not being read.
  logic [15:0] mem [0:(1<<SAW)-1];
  assign sram_rdata = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr] : 16'hA5A5;
  always @(posedge clk) if (!o_sram_ce_n && !o_sram_we_n) mem[o_sram_addr] = o_sram_data;

  // Word-level reference: word index wraps at the SRAM size.
  logic [31:0] ref_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          viol   = 0;
  logic [31:0] last_read = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr >> 2) & WORD_MASK;
  endfunction

  task automatic preload(input int w, input logic [31:0] val);
    mem[2*w]     = val[15:0];
    mem[2*w + 1] = val[31:16];
    ref_mem[w]   = val;
  endtask

  // Protocol rules checked continuously on every sampled cycle.
  logic           prev_we = 1'b1, prev_doe = 1'b0;
  logic [SAW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!o_sram_oe_n && o_sram_data_oe) viol++;
    if (o_sram_lb_n != o_sram_ce_n || o_sram_ub_n != o_sram_ce_n) viol++;
    if ((!o_sram_we_n || !o_sram_oe_n) && o_sram_ce_n) viol++;
    if (!o_sram_we_n && !o_sram_data_oe) viol++;
    if (prev_we && !o_sram_we_n && (o_sram_addr != prev_addr || o_sram_data_oe != prev_doe)) viol++;
    prev_we   = o_sram_we_n;
    prev_doe  = o_sram_data_oe;
    prev_addr = o_sram_addr;
  end

  // One bus access, starting at a negedge in IDLE and returning at a negedge
  // one cycle after the ready pulse with the bus released.
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit early_drop, output logic [31:0] rdata);
    int lat, we_falls, we_low, oe_low, seq_err, w;
    bit seen;
    logic pw;
    logic [SAW-1:0] lo;
    logic [31:0] exp;
    lo = {addr[SAW:2], 1'b0};
    w  = word_of(addr);
    exp = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    lat = 0; we_falls = 0; we_low = 0; oe_low = 0; seq_err = 0; seen = 0; pw = 1'b1;
    i_enable = 1'b1; i_rw = rw; i_address = addr; i_wdata = wdata;
    @(posedge clk);
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        i_address = $urandom; i_wdata = $urandom; i_rw = ~rw;
        if (early_drop) i_enable = 1'b0;
      end
      if (pw && !o_sram_we_n) we_falls++;
      if (!o_sram_we_n) begin
        we_low++;
        if (o_sram_addr != ((we_falls == 1) ? lo : (lo | 1'b1))) seq_err++;
        if (o_sram_data != ((we_falls == 1) ? wdata[15:0] : wdata[31:16])) seq_err++;
      end
      if (!o_sram_oe_n) begin
        oe_low++;
        if (o_sram_addr != ((oe_low <= P) ? lo : (lo | 1'b1))) seq_err++;
      end
      pw = o_sram_we_n;
      if (o_ready) seen = 1;
    end
    i_enable = 1'b0;
    rdata = o_rdata;
    check("ready_latency", lat, seen ? (rw ? 2*P + 5 : 2*P + 1) : 0);
    check("we_pulses", we_falls, rw ? 2 : 0);
    check("we_low_cycles", we_low, rw ? 2*P : 0);
    check("oe_low_cycles", oe_low, rw ? 0 : 2*P);
    check("addr_data_seq", seq_err, 0);
    if (rw) begin
      ref_mem[w] = wdata;
      check("rdata_hold", rdata, last_read);
    end else begin
      check("read_data", rdata, exp);
      last_read = rdata;
    end
    @(negedge clk);
    check("ready_single_pulse", o_ready, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, addr;
    int idle_readys, idle_busy;
    i_reset = 1'b1; i_enable = 1'b1; i_rw = 1'b0; i_address = 32'h10; i_wdata = 32'h0;
    for (int w = 0; w < 16; w++) preload(w, $urandom);
    preload(4, 32'h1234_5678);

    // Reset with a pending request: nothing may start.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n}, 5'b11111);
    check("reset_data_oe", o_sram_data_oe, 1'b0);
    check("reset_ready", o_ready, 1'b0);
    check("reset_rdata", o_rdata, 32'h0);
    check("reset_addr", o_sram_addr, '0);
    i_reset = 1'b0; i_enable = 1'b0;
    @(negedge clk);

    access(1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("read_0x10", rd, 32'h1234_5678);

    access(1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, rd);
    check("mem_hw4", mem[4], 16'hBEEF);
    check("mem_hw5", mem[5], 16'hDEAD);

    access(1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, rd);
    access(1'b0, 32'h0008_0000, 32'h0, 1'b0, rd);
    check("wrap_read", rd, 32'hCAFE_F00D);

    // Early drop: access still completes, no second access afterwards.
    access(1'b0, 32'h08, 32'h0, 1'b1, rd);
    check("early_drop_read", rd, 32'hDEAD_BEEF);
    idle_readys = 0; idle_busy = 0;
    repeat (2*P + 6) begin
      @(negedge clk);
      if (o_ready) idle_readys++;
      if (!o_sram_ce_n) idle_busy++;
    end
    check("early_drop_no_ready", idle_readys, 0);
    check("early_drop_no_access", idle_busy, 0);

    // Reset during the high-half write pulse.
    i_enable = 1'b1; i_rw = 1'b1; i_address = 32'h190; i_wdata = 32'h0BAD_F00D;
    @(posedge clk);
    repeat (P + 4) @(negedge clk);
    i_enable = 1'b0;
    check("midwr_we_low", o_sram_we_n, 1'b0);
    i_reset = 1'b1;
    @(negedge clk);
    check("midwr_we_high", o_sram_we_n, 1'b1);
    check("midwr_ce_high", o_sram_ce_n, 1'b1);
    check("midwr_ready", o_ready, 1'b0);
    i_reset = 1'b0;
    last_read = 32'h0;
    idle_readys = 0;
    repeat (2*P + 6) begin
      @(negedge clk);
      if (o_ready) idle_readys++;
    end
    check("midwr_no_ready", idle_readys, 0);
    access(1'b0, 32'h10, 32'h0, 1'b0, rd);

    // Random traffic over a few words, with aliasing upper address bits.
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      access(1'($urandom_range(0, 1)), addr, $urandom, 1'b0, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Synthesizable replacement for the behavioural SRAM model on the CPU data/instruction bus. Sits directly downstream of the bus address decoder, which asserts `i_enable` for the SRAM window and presents a base-relative byte address. Converts each 32-bit bus access into two sequenced 16-bit accesses on an external asynchronous SRAM (IS61WV-class), and returns `o_ready` when the word is complete.

## Interface
Parameters:
- `SRAM_ADDR_WIDTH`, 18: external half-word address width.
- `PHASE_CYCLES`, 2: cycles `oe_n` is held low per read half, and `we_n` per write half; must be ≥1.

Ports:
- `i_clock`  in  1  sole clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  access request from the decoder; held high until `o_ready`.
- `i_rw`  in  1  1 = write, 0 = read.
- `i_address`  in  32  base-relative byte address; bits [1:0] ignored.
- `i_wdata`  in  32  write word; sampled when the request is accepted.
- `o_rdata`  out  32  read word; valid while `o_ready` is high, held until the next read completes.
- `o_ready`  out  1  single-cycle completion pulse.
- `o_sram_addr`  out  SRAM_ADDR_WIDTH  external half-word address.
- `o_sram_data`  out  16  external write data.
- `i_sram_data`  in  16  external read data.
- `o_sram_data_oe`  out  1  tristate enable for `o_sram_data`; the top level builds the inout.
- `o_sram_ce_n`, `o_sram_oe_n`, `o_sram_we_n`, `o_sram_lb_n`, `o_sram_ub_n`  out  1 each  active-low SRAM strobes.

## Operation
- Half-word addresses: `lo = {i_address[SRAM_ADDR_WIDTH:2], 1'b0}`, `hi = lo | 1`. Upper address bits are discarded, so accesses wrap modulo 2^(SRAM_ADDR_WIDTH+1) bytes.
- Data mapping: word[15:0] is at `lo`, word[31:16] is at `hi`. Writes are always full-word; `lb_n` and `ub_n` are both low whenever `ce_n` is low.
- The request (address, rw, wdata) is latched on the IDLE edge where `i_enable` = 1. Later bus changes do not affect the access in flight.
- State machine, with every output registered:
  - IDLE: all strobes high, `data_oe` = 0. If `i_enable` is high, go to RD_LO when `i_rw` = 0, or WR_LO_SETUP when `i_rw` = 1.
  - Read path: RD_LO (PHASE_CYCLES) → RD_HI (PHASE_CYCLES) → DONE.
    - `ce_n` and `oe_n` are low throughout.
    - `i_sram_data` is captured on the last cycle of each phase, into rdata[15:0] and rdata[31:16] respectively.
  - Write path: WR_LO_SETUP (1) → WR_LO_PULSE (PHASE_CYCLES) → WR_LO_HOLD (1) → WR_HI_SETUP (1) → WR_HI_PULSE (PHASE_CYCLES) → WR_HI_HOLD (1) → DONE.
    - `ce_n` is low throughout and `oe_n` stays high.
    - `we_n` is low only in the PULSE states.
    - Address and data are stable through SETUP, PULSE and HOLD of each half.
    - `data_oe` is 1 from WR_LO_SETUP through WR_HI_HOLD.
  - DONE: `o_ready` = 1 and all strobes are high. Go to IDLE.
- Once accepted, an access always completes even if `i_enable` drops. `o_ready` still pulses, and the decoder ignores it.
- `i_enable` still high in the cycle after DONE is treated as a new request.
- Reset values (any state, next edge):
  - state = IDLE.
  - `o_ready` = 0, `o_rdata` = 0.
  - `o_sram_addr` = 0, `o_sram_data` = 0, `o_sram_data_oe` = 0.
  - `ce_n`, `oe_n`, `we_n`, `lb_n`, `ub_n` all = 1.
- Reset mid-write: `we_n` goes high on the reset edge and no `o_ready` is issued. A partially written word is left as-is.

## Timing
- Edge 0 is the accepting edge.
- Read: `o_ready` is high during cycle 2·PHASE_CYCLES+1, i.e. 5 cycles with default parameters.
- Write: `o_ready` is high during cycle 2·PHASE_CYCLES+5, i.e. 9 cycles with default parameters.
- Back-to-back: the minimum gap between an `o_ready` pulse and the next accepting edge is one IDLE cycle.
- `we_n` never falls in the same cycle that the address or `data_oe` changes.
- `oe_n` and `data_oe` are never both active.

## Test plan
- Reset: drive `i_reset` = 1 for 2 cycles with `i_enable` = 1 → all strobes 1, `data_oe` = 0, `o_ready` = 0, `o_rdata` = 0; no access starts.
- Read: SRAM model holds half-word 8 = 0x5678 and half-word 9 = 0x1234; issue read at `i_address` = 0x10 → `o_sram_addr` is 8 then 9, `o_rdata` = 0x12345678, `o_ready` is a single pulse 5 cycles after acceptance.
- Write: write 0xDEADBEEF at `i_address` = 0x08 → model half-word 4 = 0xBEEF and half-word 5 = 0xDEAD; exactly 2 `we_n` pulses of 2 cycles each; `o_ready` 9 cycles after acceptance; `oe_n` stays 1 throughout.
- Back-to-back and wrap: write 0xCAFEF00D to 0x0, drop `i_enable` for one cycle, then read address 0x80000 (wraps to 0) → read returns 0xCAFEF00D.
- Early drop: begin a read, drop `i_enable` after 1 cycle → access completes, a single `o_ready` pulse occurs, and no second access starts.
- Reset mid-write: assert `i_reset` during WR_HI_PULSE → `we_n` = 1 on the next edge, no `o_ready`, state returns to IDLE; a following read completes normally.
